// File: rtl/pixel_shader_tile.sv
// pixel_shader_tile: rasterizes a voxel stream onto a tile of LANES adjacent
// pixels (orthographic, nearest hit per lane), then shades each lane through
// a palette req/rsp port and streams the pixels out with backpressure.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 frame start (honoured in IDLE/DONE only)
//   i_row, i_col_base       tile row and column of lane 0
//   i_proj_axis             0:-z 1:-x 2:-y 3:reserved (no hits)
//   i_cam_pos_x/y/z         signed camera position, Q(COORD.FRACT)
//   i_voxel_*/o_voxel_ready voxel stream (valid/ready, last marks frame end)
//   o_pal_req_*/i_pal_rsp_* palette lookup, response latency >= 1 cycle
//   o_pix_*/i_pix_ready     output pixel stream (valid/ready)
//   o_done                  one-cycle pulse after the final pixel is accepted

module pixel_shader_tile #(
    parameter int LANES        = 4,
    parameter int COORD_BITS   = 8,
    parameter int FRACT_BITS   = 8,
    parameter int PALETTE_BITS = 8,
    parameter int PIXEL_BITS   = 8,
    parameter int ROW_BITS     = 8,
    parameter int COL_BITS     = 8,
    parameter logic [PIXEL_BITS-1:0] BG_COLOR = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [ROW_BITS-1:0]              i_row,
    input  logic [COL_BITS-1:0]              i_col_base,
    input  logic [1:0]                       i_proj_axis,
    input  logic [COORD_BITS+FRACT_BITS-1:0] i_cam_pos_x,
    input  logic [COORD_BITS+FRACT_BITS-1:0] i_cam_pos_y,
    input  logic [COORD_BITS+FRACT_BITS-1:0] i_cam_pos_z,
    input  logic                             i_voxel_valid,
    output logic                             o_voxel_ready,
    input  logic [COORD_BITS-1:0]            i_voxel_x,
    input  logic [COORD_BITS-1:0]            i_voxel_y,
    input  logic [COORD_BITS-1:0]            i_voxel_z,
    input  logic [PALETTE_BITS-1:0]          i_voxel_id,
    input  logic                             i_voxel_last,
    output logic                             o_pal_req_valid,
    output logic [PALETTE_BITS-1:0]          o_pal_req_id,
    input  logic                             i_pal_rsp_valid,
    input  logic [PIXEL_BITS-1:0]            i_pal_rsp_data,
    output logic                             o_pix_valid,
    input  logic                             i_pix_ready,
    output logic [COL_BITS-1:0]              o_pix_col,
    output logic [PIXEL_BITS-1:0]            o_pix_data,
    output logic                             o_done
);

    localparam int CW = COORD_BITS + FRACT_BITS;
    localparam int DW = CW + 1;
    localparam int EW = CW + 2;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [FRACT_BITS-1:0] HALF =
        FRACT_BITS'(1) << (FRACT_BITS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RASTER,
        S_DRAIN,
        S_SHADE_REQ,
        S_SHADE_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ROW_BITS-1:0]     r_row;
    logic [COL_BITS-1:0]     r_col_base;
    logic [1:0]              r_axis;
    logic [CW-1:0]           r_cam_x;
    logic [CW-1:0]           r_cam_y;
    logic [CW-1:0]           r_cam_z;

    logic                    r_s1_valid;
    logic [LANES-1:0]        r_s1_mask;
    logic [DW-1:0]           r_s1_d;
    logic [PALETTE_BITS-1:0] r_s1_id;

    logic [DW-1:0]           r_depth [LANES];
    logic [PALETTE_BITS-1:0] r_id    [LANES];

    logic [LW-1:0]           r_lane;
    logic                    r_drain;
    logic [PIXEL_BITS-1:0]   r_color;
    logic                    r_done;

    logic                    w_start;
    logic                    w_vox_fire;
    logic [COORD_BITS-1:0]   w_a;
    logic [COORD_BITS-1:0]   w_b;
    logic [COORD_BITS-1:0]   w_c;
    logic [CW-1:0]           w_cam;
    logic                    w_axis_ok;
    logic [EW-1:0]           w_d_ext;
    logic                    w_front;
    logic [COL_BITS-1:0]     w_a_col;
    logic [ROW_BITS-1:0]     w_b_row;
    logic [LANES-1:0]        w_hit;
    logic [PALETTE_BITS-1:0] w_lane_id;
    logic [PALETTE_BITS-1:0] w_prev_id;
    logic                    w_reuse;
    logic                    w_last_lane;
    logic                    w_req;

    assign w_start    = i_start &&
                        (r_state == S_IDLE || r_state == S_DONE);
    assign w_vox_fire = i_voxel_valid && (r_state == S_RASTER);

    // Map voxel coordinates onto screen column (a), row (b), depth (c).
    always_comb begin
        w_a       = i_voxel_x;
        w_b       = i_voxel_y;
        w_c       = i_voxel_z;
        w_cam     = r_cam_z;
        w_axis_ok = 1'b1;
        case (r_axis)
            2'd1: begin
                w_a   = i_voxel_z;
                w_c   = i_voxel_x;
                w_cam = r_cam_x;
            end
            2'd2: begin
                w_b   = i_voxel_z;
                w_c   = i_voxel_y;
                w_cam = r_cam_y;
            end
            2'd3: begin
                w_axis_ok = 1'b0;
            end
            default: begin
                w_a   = i_voxel_x;
                w_b   = i_voxel_y;
            end
        endcase
    end

    // Depth along the view direction: camera minus voxel centre. Two guard
    // bits keep extreme camera/voxel pairs from wrapping into a false hit;
    // any positive result fits the DW-bit depth buffer.
    assign w_d_ext = {{2{w_cam[CW-1]}}, w_cam} - {2'b00, w_c, HALF};
    assign w_front = !w_d_ext[EW-1] && (w_d_ext != '0);
    assign w_a_col = COL_BITS'(w_a);
    assign w_b_row = ROW_BITS'(w_b);

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hit[i] = w_axis_ok && w_front &&
                       (w_a_col == r_col_base + COL_BITS'(i)) &&
                       (w_b_row == r_row);
        end
    end

    // S1 holds hit mask and depth; S2 compares and writes the lane buffers.
    // Compare and write share one stage, so a back-to-back voxel on the
    // same lane always sees the freshly written depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_d     <= '0;
            r_s1_id    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_depth[i] <= '1;
                r_id[i]    <= '0;
            end
        end else begin
            r_s1_valid <= w_vox_fire;
            r_s1_mask  <= w_hit;
            r_s1_d     <= w_d_ext[DW-1:0];
            r_s1_id    <= i_voxel_id;
            if (w_start) begin
                for (int i = 0; i < LANES; i++) begin
                    r_depth[i] <= '1;
                    r_id[i]    <= '0;
                end
            end else if (r_s1_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    if (r_s1_mask[i] && (r_s1_d < r_depth[i])) begin
                        r_depth[i] <= r_s1_d;
                        r_id[i]    <= r_s1_id;
                    end
                end
            end
        end
    end

    assign w_lane_id   = r_id[r_lane];
    assign w_prev_id   = r_id[r_lane - LW'(1)];
    assign w_reuse     = (r_lane != '0) && (w_lane_id == w_prev_id);
    assign w_last_lane = (r_lane == LAST_LANE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_RASTER;
                end
            end
            S_RASTER: begin
                if (i_voxel_valid && i_voxel_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = S_SHADE_REQ;
                end
            end
            S_SHADE_REQ: begin
                if (w_lane_id == '0 || w_reuse) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_req       = 1'b1;
                    w_state_nxt = S_SHADE_WAIT;
                end
            end
            S_SHADE_WAIT: begin
                if (i_pal_rsp_valid) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (i_pix_ready) begin
                    w_state_nxt = w_last_lane ? S_DONE : S_SHADE_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row      <= '0;
            r_col_base <= '0;
            r_axis     <= '0;
            r_cam_x    <= '0;
            r_cam_y    <= '0;
            r_cam_z    <= '0;
            r_lane     <= '0;
            r_drain    <= 1'b0;
            r_color    <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_start) begin
                r_row      <= i_row;
                r_col_base <= i_col_base;
                r_axis     <= i_proj_axis;
                r_cam_x    <= i_cam_pos_x;
                r_cam_y    <= i_cam_pos_y;
                r_cam_z    <= i_cam_pos_z;
                r_lane     <= '0;
            end
            r_drain <= (r_state == S_DRAIN) ? !r_drain : 1'b0;
            // r_color always holds the previous lane's colour, which is
            // what makes the same-id reuse path free.
            if (r_state == S_SHADE_REQ && w_lane_id == '0) begin
                r_color <= BG_COLOR;
            end
            if (r_state == S_SHADE_WAIT && i_pal_rsp_valid) begin
                r_color <= i_pal_rsp_data;
            end
            if (r_state == S_OUT && i_pix_ready && !w_last_lane) begin
                r_lane <= r_lane + LW'(1);
            end
            r_done <= (r_state == S_OUT) && i_pix_ready && w_last_lane;
        end
    end

    assign o_voxel_ready   = (r_state == S_RASTER);
    assign o_pal_req_valid = w_req;
    assign o_pal_req_id    = w_req ? w_lane_id : '0;
    assign o_pix_valid     = (r_state == S_OUT);
    assign o_pix_col       = (r_state == S_OUT) ?
                             r_col_base + COL_BITS'(r_lane) : '0;
    assign o_pix_data      = (r_state == S_OUT) ? r_color : '0;
    assign o_done          = r_done;

endmodule
